// File: rtl/bitblade_pkg.sv
// Shared types for the bit-slice operand feeder: geometry, precision codes,
// FSM state, operand/beat records and the precision-to-slice-count helper.
package bitblade_pkg;
  localparam int LANES    = 16;
  localparam int MAX_BITS = 8;
  localparam int SLICE    = 2;
  localparam int NSLC     = MAX_BITS / SLICE;
  localparam int IDX_W    = $clog2(NSLC);

  localparam logic [1:0] PREC_2B = 2'b00;
  localparam logic [1:0] PREC_4B = 2'b01;
  localparam logic [1:0] PREC_8B = 2'b10;

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  typedef logic [LANES-1:0][MAX_BITS-1:0] opnd_t;
  typedef logic [LANES-1:0][SLICE-1:0]    slv_t;

  // Slice counts are kept as count-1 so they fit the slice index width.
  typedef struct packed {
    opnd_t            act;
    opnd_t            wgt;
    logic [IDX_W-1:0] nxm1;
    logic [IDX_W-1:0] nym1;
    logic             sx;
    logic             sy;
  } opset_t;

  typedef struct packed {
    slv_t       x;
    slv_t       y;
    logic       sign_x;
    logic       sign_y;
    logic [3:0] shift;
    logic       first;
    logic       last;
  } beat_t;

  // Reserved code 11 falls into the default arm, i.e. 8-bit.
  function automatic logic [IDX_W:0] slice_cnt(input logic [1:0] prec);
    case (prec)
      PREC_2B: return (IDX_W+1)'(1);
      PREC_4B: return (IDX_W+1)'(2);
      default: return (IDX_W+1)'(4);
    endcase
  endfunction
endpackage

// File: rtl/pe_operand_feeder_if.sv
// Operand-set request and slice-beat response bus of the operand feeder.
interface pe_operand_feeder_if;
  import bitblade_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*MAX_BITS-1:0] act;
  logic [LANES*MAX_BITS-1:0] wgt;
  logic [1:0]                prec_x;
  logic [1:0]                prec_y;
  logic                      signed_x;
  logic                      signed_y;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*SLICE-1:0]    x;
  logic [LANES*SLICE-1:0]    y;
  logic                      sign_x;
  logic                      sign_y;
  logic [3:0]                shift;
  logic                      first;
  logic                      last;

  modport master (
    output in_valid, act, wgt, prec_x, prec_y, signed_x, signed_y, out_ready,
    input  in_ready, out_valid, x, y, sign_x, sign_y, shift, first, last
  );

  modport slave (
    input  in_valid, act, wgt, prec_x, prec_y, signed_x, signed_y, out_ready,
    output in_ready, out_valid, x, y, sign_x, sign_y, shift, first, last
  );
endinterface

// File: rtl/pe_slice_mux.sv
// One lane's slice select: picks bits [SLICE*idx +: SLICE] of an operand lane.
module pe_slice_mux #(
  parameter  int VEC_W = 8,
  parameter  int SLICE = 2,
  localparam int IDX_W = $clog2(VEC_W / SLICE)
) (
  input  logic [VEC_W-1:0] lane_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [SLICE-1:0] slice_o
);
  logic [VEC_W/SLICE-1:0][SLICE-1:0] slices;

  assign slices  = lane_i;
  assign slice_o = slices[idx_i];
endmodule

// File: rtl/pe_operand_feeder.sv
// Bit-slice sequencer: walks every (x-slice, y-slice) pair of an operand set,
// i inner and j outer, emitting one registered 2-bit-per-lane beat per handshake.
module pe_operand_feeder
  import bitblade_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  pe_operand_feeder_if.slave bus
);
  state_e           state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d, j_q, j_d;
  opset_t           op_q, op_d;
  beat_t            beat_q, beat_d;
  logic             fire_out, accept;
  logic [IDX_W:0]   cnt_x, cnt_y, ij;
  slv_t             x_slc, y_slc;

  assign fire_out     = (state_q == ST_RUN) & bus.out_ready;
  assign bus.in_ready = !reset & ((state_q == ST_IDLE) | (fire_out & beat_q.last));
  assign accept       = bus.in_valid & bus.in_ready;
  assign cnt_x        = slice_cnt(bus.prec_x) - (IDX_W+1)'(1);
  assign cnt_y        = slice_cnt(bus.prec_y) - (IDX_W+1)'(1);

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    op_d    = op_q;
    if (accept) begin
      op_d.act  = bus.act;
      op_d.wgt  = bus.wgt;
      op_d.nxm1 = cnt_x[IDX_W-1:0];
      op_d.nym1 = cnt_y[IDX_W-1:0];
      op_d.sx   = bus.signed_x;
      op_d.sy   = bus.signed_y;
      i_d       = '0;
      j_d       = '0;
      state_d   = ST_RUN;
    end else if (fire_out) begin
      if (beat_q.last) begin
        state_d = ST_IDLE;
        i_d     = '0;
        j_d     = '0;
      end else if (i_q != op_q.nxm1) begin
        i_d = i_q + IDX_ONE;
      end else begin
        i_d = '0;
        j_d = j_q + IDX_ONE;
      end
    end
  end

  // Slices are taken from next-state operands/indices so the beat registers
  // already hold the first slice one cycle after accept.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    pe_slice_mux #(.VEC_W(MAX_BITS), .SLICE(SLICE)) u_xmux (
      .lane_i (op_d.act[k]),
      .idx_i  (i_d),
      .slice_o(x_slc[k])
    );
    pe_slice_mux #(.VEC_W(MAX_BITS), .SLICE(SLICE)) u_ymux (
      .lane_i (op_d.wgt[k]),
      .idx_i  (j_d),
      .slice_o(y_slc[k])
    );
  end

  always_comb begin
    beat_d = '0;
    ij     = {1'b0, i_d} + {1'b0, j_d};
    if (state_d == ST_RUN) begin
      beat_d.x      = x_slc;
      beat_d.y      = y_slc;
      beat_d.sign_x = op_d.sx && (i_d == op_d.nxm1);
      beat_d.sign_y = op_d.sy && (j_d == op_d.nym1);
      beat_d.shift  = {ij, 1'b0};
      beat_d.first  = (i_d == '0) && (j_d == '0);
      beat_d.last   = (i_d == op_d.nxm1) && (j_d == op_d.nym1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      op_q    <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      op_q    <= op_d;
      beat_q  <= beat_d;
    end
  end

  assign bus.out_valid = (state_q == ST_RUN);
  assign bus.x         = beat_q.x;
  assign bus.y         = beat_q.y;
  assign bus.sign_x    = beat_q.sign_x;
  assign bus.sign_y    = beat_q.sign_y;
  assign bus.shift     = beat_q.shift;
  assign bus.first     = beat_q.first;
  assign bus.last      = beat_q.last;
endmodule

// File: tb/tb_pe_operand_feeder.sv
// Bench for pe_operand_feeder: queue model of expected beats checked every cycle,
// plus directed literal checks on the captured beat stream.
module tb_pe_operand_feeder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pe_operand_feeder_if ifc();
  pe_operand_feeder dut (.clk(clk), .reset(reset), .bus(ifc.slave));

  typedef struct {
    logic [31:0] x, y;
    logic        sx, sy;
    logic [3:0]  sh;
    logic        f, l;
  } ebeat_t;

  ebeat_t expq[$];
  ebeat_t obs[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
    end
  endtask

  function automatic int nslc(input logic [1:0] p);
    return (p == 2'b00) ? 1 : ((p == 2'b01) ? 2 : 4);
  endfunction

  task automatic push_set(input logic [127:0] a, input logic [127:0] w,
                          input logic [1:0] px, input logic [1:0] py,
                          input logic sx, input logic sy);
    int nx, ny;
    ebeat_t b;
    nx = nslc(px);
    ny = nslc(py);
    for (int j = 0; j < ny; j++)
      for (int i = 0; i < nx; i++) begin
        b.x = '0;
        b.y = '0;
        for (int k = 0; k < 16; k++) begin
          b.x[2*k +: 2] = a[8*k + 2*i +: 2];
          b.y[2*k +: 2] = w[8*k + 2*j +: 2];
        end
        b.sx = sx && (i == nx-1);
        b.sy = sy && (j == ny-1);
        b.sh = 4'(2*(i+j));
        b.f  = (i == 0) && (j == 0);
        b.l  = (i == nx-1) && (j == ny-1);
        expq.push_back(b);
      end
  endtask

  // Per-cycle compare against the model queue.
  initial begin
    logic er;
    ebeat_t d;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("in_ready_in_reset", {31'b0, ifc.in_ready}, 32'd0);
        expq.delete();
      end else begin
        er = (expq.size() == 0) || (ifc.out_ready && expq[0].l);
        chk("in_ready", {31'b0, ifc.in_ready}, {31'b0, er});
        chk("out_valid", {31'b0, ifc.out_valid}, {31'b0, expq.size() != 0});
        if (expq.size() != 0) begin
          chk("x", ifc.x, expq[0].x);
          chk("y", ifc.y, expq[0].y);
          chk("flags", {25'b0, ifc.sign_x, ifc.sign_y, ifc.shift, ifc.first, ifc.last},
              {25'b0, expq[0].sx, expq[0].sy, expq[0].sh, expq[0].f, expq[0].l});
          if (ifc.out_ready) begin
            d.x = ifc.x; d.y = ifc.y; d.sx = ifc.sign_x; d.sy = ifc.sign_y;
            d.sh = ifc.shift; d.f = ifc.first; d.l = ifc.last;
            obs.push_back(d);
            void'(expq.pop_front());
          end
        end else begin
          chk("idle_xy", ifc.x | ifc.y, 32'd0);
          chk("idle_flags", {25'b0, ifc.sign_x, ifc.sign_y, ifc.shift, ifc.first, ifc.last}, 32'd0);
        end
        if (ifc.in_valid && ifc.in_ready)
          push_set(ifc.act, ifc.wgt, ifc.prec_x, ifc.prec_y, ifc.signed_x, ifc.signed_y);
      end
    end
  end

  task automatic send(input logic [127:0] a, input logic [127:0] w,
                      input logic [1:0] px, input logic [1:0] py,
                      input logic sx, input logic sy);
    logic hs;
    hs = 1'b0;
    ifc.in_valid = 1'b1; ifc.act = a; ifc.wgt = w;
    ifc.prec_x = px; ifc.prec_y = py; ifc.signed_x = sx; ifc.signed_y = sy;
    for (int c = 0; c < 200 && !hs; c++) begin
      @(negedge clk);
      hs = ifc.in_ready;
      @(posedge clk);
      #1;
    end
    ifc.in_valid = 1'b0;
    if (!hs) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int c = 0; c < 500 && !done; c++) begin
      if (expq.size() == 0 && !ifc.out_valid) done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int base;
    logic [127:0] ra, rw;
    logic [31:0] snap;
    logic [3:0] sh8 [16];
    logic [1:0] x3 [4];
    logic       sx3 [4];
    logic       got3;
    sh8 = '{0,2,4,6, 2,4,6,8, 4,6,8,10, 6,8,10,12};
    x3  = '{2'b10, 2'b11, 2'b10, 2'b11};
    sx3 = '{1'b0, 1'b1, 1'b0, 1'b1};
    ifc.in_valid = 0; ifc.act = '0; ifc.wgt = '0; ifc.prec_x = 0; ifc.prec_y = 0;
    ifc.signed_x = 0; ifc.signed_y = 0; ifc.out_ready = 1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, ifc.out_valid}, 32'd0);
    chk("rst_xy", ifc.x | ifc.y, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", {31'b0, ifc.in_ready}, 32'd1);
    @(posedge clk); #1;

    // 1: 2x2 unsigned single beat
    base = obs.size();
    send(128'h03, 128'h01, 2'b00, 2'b00, 0, 0);
    drain();
    chk("t1_count", obs.size() - base, 32'd1);
    chk("t1_x", obs[base].x, 32'h3);
    chk("t1_y", obs[base].y, 32'h1);
    chk("t1_flags", {29'b0, obs[base].sh == 0, obs[base].f, obs[base].l}, 32'h7);

    // 2: 8x8 unsigned, shift sequence
    base = obs.size();
    ra = {$urandom, $urandom, $urandom, $urandom};
    rw = {$urandom, $urandom, $urandom, $urandom};
    send(ra, rw, 2'b10, 2'b10, 0, 0);
    drain();
    chk("t2_count", obs.size() - base, 32'd16);
    for (int b = 0; b < 16 && base + b < obs.size(); b++) begin
      chk("t2_shift", {28'b0, obs[base+b].sh}, {28'b0, sh8[b]});
      chk("t2_last", {31'b0, obs[base+b].l}, {31'b0, b == 15});
    end

    // 3: 4x4, signed act lane0=-2
    base = obs.size();
    send(128'h0E, 128'h0, 2'b01, 2'b01, 1, 0);
    drain();
    chk("t3_count", obs.size() - base, 32'd4);
    for (int b = 0; b < 4 && base + b < obs.size(); b++) begin
      got3 = obs[base+b].sx;
      chk("t3_x0", {30'b0, obs[base+b].x[1:0]}, {30'b0, x3[b]});
      chk("t3_sign_x", {31'b0, got3}, {31'b0, sx3[b]});
      chk("t3_sign_y", {31'b0, obs[base+b].sy}, 32'd0);
    end

    // 4: backpressure on beat 2 of 4x2
    base = obs.size();
    ra = {$urandom, $urandom, $urandom, $urandom};
    send(ra, 128'h5A5A, 2'b01, 2'b00, 0, 0);
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    snap = ifc.x;
    repeat (5) begin @(posedge clk); #1; end
    chk("t4_hold_x", ifc.x, snap);
    chk("t4_hold_valid", {31'b0, ifc.out_valid}, 32'd1);
    ifc.out_ready = 1'b1;
    drain();
    chk("t4_count", obs.size() - base, 32'd2);
    if (obs.size() - base == 2)
      chk("t4_shift", {24'b0, obs[base].sh, obs[base+1].sh}, 32'h02);

    // 5: back-to-back 2x4 operations
    base = obs.size();
    send(128'h1B, 128'hC6, 2'b00, 2'b01, 0, 1);
    send(128'h22, 128'h33, 2'b00, 2'b01, 1, 0);
    chk("t5_accept_on_last", obs.size() - base, 32'd2);
    @(negedge clk);
    chk("t5_first", {30'b0, ifc.out_valid, ifc.first}, 32'h3);
    @(posedge clk); #1;
    drain();
    chk("t5_count", obs.size() - base, 32'd4);

    // 6: reset mid-operation
    base = obs.size();
    send(ra, rw, 2'b10, 2'b10, 1, 1);
    for (int c = 0; c < 100 && obs.size() < base + 3; c++) begin @(posedge clk); #1; end
    chk("t6_three_beats", obs.size() - base, 32'd3);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_valid", {31'b0, ifc.out_valid}, 32'd0);
    chk("t6_rst_xy", ifc.x | ifc.y, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t6_rdy", {31'b0, ifc.in_ready}, 32'd1);
    @(posedge clk); #1;
    base = obs.size();
    send(128'h02 << 40, 128'h03 << 40, 2'b00, 2'b00, 0, 0);
    drain();
    chk("t6_count", obs.size() - base, 32'd1);
    chk("t6_x", obs[base].x, 32'h800);
    chk("t6_y", obs[base].y, 32'hC00);
    chk("t6_first", {31'b0, obs[base].f}, 32'd1);

    // 7: reserved precision, upper lane bits ignored
    base = obs.size();
    ra = {$urandom, $urandom, $urandom, $urandom};
    rw = {$urandom, $urandom, $urandom, $urandom};
    send(ra, rw, 2'b11, 2'b00, 1, 1);
    drain();
    chk("t7_count", obs.size() - base, 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
